// File: rtl/win_scanner_if.sv
// Request/result bundle between the game controller and the win scanner.
// The controller side uses the master modport, the scanner the slave modport.
interface win_scanner_if #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int WIN_LEN = 4
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int LW = $clog2(WIN_LEN + 1);

    logic                   start;
    logic [RW-1:0]          move_row;
    logic [CW-1:0]          move_col;
    logic [ROWS*COLS*2-1:0] board_in;
    logic                   busy;
    logic                   done;
    logic [1:0]             winner;
    logic [1:0]             win_axis;
    logic [LW-1:0]          run_len;

    modport master (
        output start, move_row, move_col, board_in,
        input  busy, done, winner, win_axis, run_len
    );

    modport slave (
        input  start, move_row, move_col, board_in,
        output busy, done, winner, win_axis, run_len
    );
endinterface

// File: rtl/win_scanner.sv
// Connect-N victory checker. Snapshots the board on start, then walks out from
// the last-played cell one cell per clock along four axes, counting contiguous
// pieces of the mover's colour, and stops on the first run of WIN_LEN.
module win_scanner #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int WIN_LEN = 4
) (
    input  logic         clk,
    input  logic         rst,
    win_scanner_if.slave bus
);
    localparam int RW  = $clog2(ROWS);
    localparam int CW  = $clog2(COLS);
    localparam int LW  = $clog2(WIN_LEN + 1);
    localparam int RW1 = RW + 1;
    localparam int CW1 = CW + 1;
    localparam int BW  = ROWS * COLS * 2;

    localparam logic [LW-1:0]        WIN_CNT = LW'(WIN_LEN);
    localparam logic signed [RW:0]   R_ONE   = RW1'(1);
    localparam logic signed [CW:0]   C_ONE   = CW1'(1);

    typedef enum logic [2:0] {IDLE, LOAD, POS, NEG, DONE} state_t;

    state_t             state;
    logic [BW-1:0]      snap;
    logic [RW-1:0]      move_r;
    logic [CW-1:0]      move_c;
    logic signed [RW:0] cur_r, vec_r, step_r, cand_r;
    logic signed [CW:0] cur_c, vec_c, step_c, cand_c;
    logic [1:0]         piece, axis, move_cell, cand_cell;
    logic [LW-1:0]      count, count_inc;
    logic               move_ok, cand_ok, cand_match;

    logic               busy_q, done_q;
    logic [1:0]         winner_q, win_axis_q;
    logic [LW-1:0]      run_len_q;

    // Two-bit cell (r,c) of a packed board; shifting avoids a wide select index.
    function automatic logic [1:0] cell_at(input logic [BW-1:0] b, input int r, input int c);
        logic [BW-1:0] sh;
        sh = b >> (2 * (r * COLS + c));
        return sh[1:0];
    endfunction

    // Candidate cell for the current axis/direction and the move-cell lookup.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        vec_r     = '0;
        vec_c     = '0;
        cand_cell = 2'b00;
        move_cell = 2'b00;
        case (axis)
            2'd0:    vec_c = C_ONE;
            2'd1:    vec_r = R_ONE;
            2'd2:    begin vec_r = R_ONE; vec_c = C_ONE;  end
            default: begin vec_r = R_ONE; vec_c = -C_ONE; end
        endcase
        step_r = (state == NEG) ? -vec_r : vec_r;
        step_c = (state == NEG) ? -vec_c : vec_c;
        cand_r = cur_r + step_r;
        cand_c = cur_c + step_c;
        // Read as unsigned, -1 becomes all ones, so one compare rejects both
        // edges; wrap-around into the next row can never look adjacent.
        cand_ok = (int'($unsigned(cand_r)) < ROWS) && (int'($unsigned(cand_c)) < COLS);
        if (cand_ok)
            cand_cell = cell_at(snap, int'($unsigned(cand_r)), int'($unsigned(cand_c)));
        cand_match = cand_ok && (cand_cell == piece);
        count_inc  = count + 1'b1;
        move_ok    = (int'(move_r) < ROWS) && (int'(move_c) < COLS);
        if (move_ok)
            move_cell = cell_at(snap, int'(move_r), int'(move_c));
    end

    // Capture the board and move when a request is accepted.
    // NOTE: the snapshot has no reset; it is always reloaded before LOAD reads it.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            snap   <= bus.board_in;
            move_r <= bus.move_row;
            move_c <= bus.move_col;
        end
    end

    // Scan sequencer with registered results.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others.
        if (rst) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            winner_q   <= 2'b00;
            win_axis_q <= 2'd0;
            run_len_q  <= '0;
            piece      <= 2'b00;
            axis       <= 2'd0;
            count      <= '0;
            cur_r      <= '0;
            cur_c      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q     <= 1'b1;
                        winner_q   <= 2'b00;
                        win_axis_q <= 2'd0;
                        run_len_q  <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (!move_ok || move_cell == 2'b00 || move_cell == 2'b11) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        piece <= move_cell;
                        axis  <= 2'd0;
                        count <= LW'(1);
                        cur_r <= {1'b0, move_r};
                        cur_c <= {1'b0, move_c};
                        state <= POS;
                    end
                end
                POS, NEG: begin
                    if (cand_match) begin
                        count <= count_inc;
                        cur_r <= cand_r;
                        cur_c <= cand_c;
                        if (count_inc == WIN_CNT) begin
                            winner_q   <= piece;
                            win_axis_q <= axis;
                            run_len_q  <= WIN_CNT;
                            done_q     <= 1'b1;
                            state      <= DONE;
                        end
                    end else if (state == POS) begin
                        cur_r <= {1'b0, move_r};
                        cur_c <= {1'b0, move_c};
                        state <= NEG;
                    end else begin
                        if (count > run_len_q)
                            run_len_q <= count;
                        if (axis == 2'd3) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            axis  <= axis + 2'd1;
                            count <= LW'(1);
                            cur_r <= {1'b0, move_r};
                            cur_c <= {1'b0, move_c};
                            state <= POS;
                        end
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.winner   = winner_q;
    assign bus.win_axis = win_axis_q;
    assign bus.run_len  = run_len_q;
endmodule

// File: doc/win_scanner.md
# win_scanner

Parametrised connect-N victory checker for an arbitrary ROWS x COLS board and run length WIN_LEN. On `start` it snapshots the board, takes the piece at the last-played cell, and walks outward from that cell one board cell per clock along four axes, counting contiguous matching pieces. It terminates early on the first winning run and reports the winner, the winning axis and the run length. It replaces the fixed 8x8, connect-4, 13-direction checker in the game controller.

## Interface

**Parameters**
- `ROWS`, default 8: board rows; row 0 is the bottom row.
- `COLS`, default 8: board columns.
- `WIN_LEN`, default 4: run length that wins; legal range is 2..max(ROWS,COLS).
- Derived widths:
  - RW = $clog2(ROWS)
  - CW = $clog2(COLS)
  - LW = $clog2(WIN_LEN+1)

**Ports**
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a check; sampled only in IDLE.
- `move_row` input RW: row of the last move.
- `move_col` input CW: column of the last move.
- `board_in` input ROWS*COLS*2: cell (r,c) occupies bits [2*(r*COLS+c)+1 : 2*(r*COLS+c)].
  - 00 = empty, 01 = player 1, 10 = player 2, 11 = invalid.
- `busy` output 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` output 1: one-cycle pulse; results are valid in that cycle.
- `winner` output 2: 00 = none, 01 or 10 = the winning player.
- `win_axis` output 2:
  - 0 = horizontal, 1 = vertical, 2 = diagonal (/), 3 = anti-diagonal (\).
  - Meaningful only when `winner` != 0.
- `run_len` output LW: the longest run found across the scanned axes, saturating at WIN_LEN.

## Operation

- **States:** IDLE, LOAD, POS, NEG, DONE.
- **IDLE:**
  - When `start`=1: latch `board_in`, `move_row` and `move_col`; clear `winner`, `win_axis` and `run_len`; go to LOAD.
  - `start` in any other state is ignored.
- **LOAD:**
  - piece = snapshot cell at (move_row, move_col).
  - If piece is 00 or 11, or the move lies off-board (row >= ROWS or col >= COLS): go to DONE with `winner`=00 and `run_len`=0.
  - Otherwise: axis=0, count=1, cursor=move, go to POS.
- **Axis step vectors (dr, dc):**
  - Positive direction: axis 0 (0,+1), axis 1 (+1,0), axis 2 (+1,+1), axis 3 (+1,-1).
  - Negative direction is the negation of the positive vector.
- **POS, one cell per cycle:** the candidate is cursor+vector.
  - If the candidate is in bounds and equals piece: count+1, cursor = candidate, stay in POS.
  - Otherwise: cursor = move, go to NEG.
- **NEG:** same rule using the negative vector. On a mismatch or out-of-bounds candidate:
  - `run_len` = max(`run_len`, count).
  - If axis < 3: axis+1, count=1, cursor=move, go to POS.
  - If axis = 3: go to DONE.
- **Early win:** when an increment makes count = WIN_LEN, in either POS or NEG:
  - `winner`=piece, `win_axis`=axis, `run_len`=WIN_LEN.
  - Go to DONE next cycle; no further cells are examined.
- **Bounds arithmetic:** candidates are computed in signed (RW+1)/(CW+1) width, so that -1 and ROWS/COLS register as out of bounds. Wrap-around is never treated as adjacency.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Result hold:** `winner`, `win_axis` and `run_len` hold until the next accepted `start`.
- **Reset:** applies in any state, including mid-scan. The state returns to IDLE and the snapshot is discarded.

## Timing

- **Reset values:**
  - `busy`=0, `done`=0, `winner`=00, `win_axis`=0, `run_len`=0.
  - Internal state = IDLE.
- **Cycle numbering:** `start` is sampled at edge 0. LOAD occupies cycle 1. Scanning begins in cycle 2.
- **Cost per scanned axis, no win:** (matching cells found) + 2 cycles.
- **Latency, no win:** `done` is high in cycle 2 + sum over axes of (matches_a + 2).
  - A lone piece gives `done` in cycle 10.
- **Latency, empty, invalid or off-board move:** `done` in cycle 2.
- **Latency, win:** `done` is high in the cycle after the increment that reached WIN_LEN.
- **Back-to-back starts:** `start` asserted in the DONE cycle is ignored. It is accepted in the first IDLE cycle, giving a minimum 1-cycle gap.
- **Snapshot:** `board_in` is don't-care after edge 0; changing it mid-scan has no effect.

## Test plan

- **Horizontal win, default parameters:**
  - Stimulus: player 1 at (0,0)-(0,3); start with move (0,3).
  - Required: `done` in cycle 6, `winner`=01, `win_axis`=0, `run_len`=4, `busy` high in cycles 1-6.
- **Lone piece:**
  - Stimulus: player 2 at (3,3) only.
  - Required: `done` in cycle 10, `winner`=00, `run_len`=1.
- **Empty cell:**
  - Stimulus: start on an empty cell.
  - Required: `done` in cycle 2, `winner`=00, `run_len`=0.
- **Anti-diagonal at the edge, no wrap:**
  - Stimulus: player 1 at (0,7), (1,6), (2,5), (3,4); move (1,6). Player 1 also at (2,0) to catch wrap-around bugs.
  - Required: `winner`=01, `win_axis`=3.
  - Separately, a horizontal run of 3 ending at col 7, plus a piece at (r+1,0): `winner`=00, `run_len`=3.
- **Generic parameters:**
  - Stimulus: ROWS=6, COLS=7, WIN_LEN=5; player 2 vertical run rows 0-4 in column 6; move (4,6).
  - Required: `winner`=10, `win_axis`=1, `run_len`=5.
  - Also WIN_LEN=5 with only 4 in a row: `winner`=00, `run_len`=4.
- **Protocol:**
  - Pulse `start` while busy: it is ignored.
  - Assert `rst` mid-scan: all outputs return to 0 asynchronously.
  - A fresh `start` after reset completes normally.
  - Changing `board_in` mid-scan does not alter the result.
